// File: rtl/sr_imem_arbiter_pkg.sv
// Shared types for the instruction-memory arbiter.
// Requester index and in-flight tag carried alongside memory latency.
package sr_imem_arb_pkg;

    localparam int NUM_REQ = 2;

    typedef logic [$clog2(NUM_REQ)-1:0] req_id_t;

    typedef struct packed {
        logic    valid;
        req_id_t id;
    } tag_t;

endpackage

// File: rtl/sr_tag_delay_line.sv
// Fixed-depth shift register of request tags that tracks which
// requester owns each memory read still in flight.
module sr_tag_delay_line
    import sr_imem_arb_pkg::*;
#(
    parameter int LAT = 1
) (
    input  logic clk,
    input  logic rst,
    input  tag_t tag_i,
    output tag_t tag_o
);

    tag_t stage_q [LAT];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < LAT; k++) begin
                stage_q[k] <= '0;
            end
        end else begin
            stage_q[0] <= tag_i;
            for (int k = 1; k < LAT; k++) begin
                stage_q[k] <= stage_q[k-1];
            end
        end
    end

    assign tag_o = stage_q[LAT-1];

endmodule

// File: rtl/sr_imem_arbiter.sv
// Round-robin arbiter sharing one pipelined fixed-latency instruction
// memory between two fetch requesters; responses routed by owner tag.
module sr_imem_arbiter
    import sr_imem_arb_pkg::*;
#(
    parameter int LAT = 1,
    parameter int AW  = 32,
    parameter int DW  = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic [AW-1:0] addr0,
    input  logic          req1,
    input  logic [AW-1:0] addr1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic [DW-1:0] rdata0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata1,
    output logic          mem_en,
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_rdata
);

    logic prio_q;
    logic prio_d;
    tag_t tag_in;
    tag_t tag_out;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            if (req0 && req1) begin
                gnt0 = ~prio_q;
                gnt1 = prio_q;
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
    end

    // addr0 doubles as the idle address so mem_addr never floats
    assign mem_en   = gnt0 | gnt1;
    assign mem_addr = gnt1 ? addr1 : addr0;

    // last winner drops to lowest priority
    always_comb begin
        prio_d = prio_q;
        if (gnt0) begin
            prio_d = 1'b1;
        end else if (gnt1) begin
            prio_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

    always_comb begin
        tag_in       = '0;
        tag_in.valid = mem_en;
        tag_in.id    = req_id_t'(gnt1);
    end

    sr_tag_delay_line #(
        .LAT (LAT)
    ) u_tags (
        .clk   (clk),
        .rst   (rst),
        .tag_i (tag_in),
        .tag_o (tag_out)
    );

    assign rvalid0 = tag_out.valid && (tag_out.id == req_id_t'(0));
    assign rvalid1 = tag_out.valid && (tag_out.id == req_id_t'(1));
    assign rdata0  = mem_rdata;
    assign rdata1  = mem_rdata;

endmodule

// File: tb/tb_sr_imem_arbiter.sv
// Directed bench: table-driven LAT=2 run plus hand sequences
// for LAT=1 back-to-back and LAT=3 reset mid-flight.
module tb_sr_imem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1;
    logic [31:0] addr0, addr1;

    always #5 clk = ~clk;

    function automatic logic [31:0] memw(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    // LAT=2 instance
    logic        g0_2, g1_2, rv0_2, rv1_2, en_2;
    logic [31:0] rd0_2, rd1_2, ma_2, mrd_2;
    logic [31:0] mp2 [2];
    // LAT=1 instance
    logic        g0_1, g1_1, rv0_1, rv1_1, en_1;
    logic [31:0] rd0_1, rd1_1, ma_1, mrd_1;
    logic [31:0] mp1;
    // LAT=3 instance
    logic        g0_3, g1_3, rv0_3, rv1_3, en_3;
    logic [31:0] rd0_3, rd1_3, ma_3, mrd_3;
    logic [31:0] mp3 [3];

    sr_imem_arbiter #(.LAT(2), .AW(32), .DW(32)) u_dut2 (
        .clk(clk), .rst(rst),
        .req0(req0), .addr0(addr0), .req1(req1), .addr1(addr1),
        .gnt0(g0_2), .gnt1(g1_2),
        .rvalid0(rv0_2), .rdata0(rd0_2), .rvalid1(rv1_2), .rdata1(rd1_2),
        .mem_en(en_2), .mem_addr(ma_2), .mem_rdata(mrd_2)
    );

    sr_imem_arbiter #(.LAT(1), .AW(32), .DW(32)) u_dut1 (
        .clk(clk), .rst(rst),
        .req0(req0), .addr0(addr0), .req1(req1), .addr1(addr1),
        .gnt0(g0_1), .gnt1(g1_1),
        .rvalid0(rv0_1), .rdata0(rd0_1), .rvalid1(rv1_1), .rdata1(rd1_1),
        .mem_en(en_1), .mem_addr(ma_1), .mem_rdata(mrd_1)
    );

    sr_imem_arbiter #(.LAT(3), .AW(32), .DW(32)) u_dut3 (
        .clk(clk), .rst(rst),
        .req0(req0), .addr0(addr0), .req1(req1), .addr1(addr1),
        .gnt0(g0_3), .gnt1(g1_3),
        .rvalid0(rv0_3), .rdata0(rd0_3), .rvalid1(rv1_3), .rdata1(rd1_3),
        .mem_en(en_3), .mem_addr(ma_3), .mem_rdata(mrd_3)
    );

    // memory models: pipelined reads, never flushed by rst
    always @(posedge clk) begin
        mp1    <= memw(ma_1);
        mp2[0] <= memw(ma_2);
        mp2[1] <= mp2[0];
        mp3[0] <= memw(ma_3);
        mp3[1] <= mp3[0];
        mp3[2] <= mp3[1];
    end
    assign mrd_1 = mp1;
    assign mrd_2 = mp2[1];
    assign mrd_3 = mp3[2];

    int n_pass = 0;
    int n_tot  = 0;

    task automatic check(input string nm, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp) begin
            $display("FAIL %s @%0d: got %h want %h", nm, idx, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic drive(input logic r, input logic q0, input logic q1,
                         input logic [31:0] a0, input logic [31:0] a1);
        rst   = r;
        req0  = q0;
        req1  = q1;
        addr0 = a0;
        addr1 = a1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        rst, r0, r1;
        logic [31:0] a0, a1;
        logic        g0, g1, en;
        logic [31:0] ma;
        logic        rv0, rv1;
        logic [31:0] rd;
    } vec_t;

    localparam int NV = 24;
    vec_t tbl [NV];

    function automatic vec_t mk(
        input logic r, input logic q0, input logic q1,
        input logic [31:0] a0, input logic [31:0] a1,
        input logic g0, input logic g1, input logic [31:0] ma,
        input logic v0, input logic v1, input logic [31:0] rd);
        vec_t v;
        v.rst = r;  v.r0 = q0; v.r1 = q1;
        v.a0  = a0; v.a1 = a1;
        v.g0  = g0; v.g1 = g1; v.en = g0 | g1;
        v.ma  = ma;
        v.rv0 = v0; v.rv1 = v1; v.rd = rd;
        return v;
    endfunction

    initial begin
        // rst  r0 r1  a0     a1      g0 g1  maddr   rv0 rv1 rdata
        tbl[0]  = mk(1, 1, 1, 'h05, 'h06,  0, 0, 'h05,  0, 0, 0);
        tbl[1]  = mk(0, 0, 0, 'h07, 'h08,  0, 0, 'h07,  0, 0, 0);
        tbl[2]  = mk(0, 1, 0, 'h10, 'h00,  1, 0, 'h10,  0, 0, 0);
        tbl[3]  = mk(0, 0, 0, 'h00, 'h00,  0, 0, 'h00,  0, 0, 0);
        tbl[4]  = mk(0, 0, 0, 'h00, 'h00,  0, 0, 'h00,  1, 0, memw('h10));
        tbl[5]  = mk(0, 0, 0, 'h00, 'h00,  0, 0, 'h00,  0, 0, 0);
        tbl[6]  = mk(0, 0, 1, 'h00, 'h20,  0, 1, 'h20,  0, 0, 0);
        tbl[7]  = mk(0, 1, 1, 'h30, 'h40,  1, 0, 'h30,  0, 0, 0);
        tbl[8]  = mk(0, 1, 1, 'h31, 'h40,  0, 1, 'h40,  0, 1, memw('h20));
        tbl[9]  = mk(0, 1, 1, 'h31, 'h41,  1, 0, 'h31,  1, 0, memw('h30));
        tbl[10] = mk(0, 1, 1, 'h32, 'h41,  0, 1, 'h41,  0, 1, memw('h40));
        tbl[11] = mk(0, 0, 0, 'h55, 'h00,  0, 0, 'h55,  1, 0, memw('h31));
        tbl[12] = mk(0, 0, 0, 'h00, 'h00,  0, 0, 'h00,  0, 1, memw('h41));
        tbl[13] = mk(0, 1, 1, 'h60, 'h70,  1, 0, 'h60,  0, 0, 0);
        tbl[14] = mk(0, 0, 0, 'h00, 'h00,  0, 0, 'h00,  0, 0, 0);
        tbl[15] = mk(0, 0, 0, 'h00, 'h00,  0, 0, 'h00,  1, 0, memw('h60));
        tbl[16] = mk(0, 0, 0, 'h00, 'h00,  0, 0, 'h00,  0, 0, 0);
        tbl[17] = mk(0, 0, 1, 'h00, 'h80,  0, 1, 'h80,  0, 0, 0);
        tbl[18] = mk(0, 1, 0, 'h90, 'h00,  1, 0, 'h90,  0, 0, 0);
        tbl[19] = mk(0, 0, 1, 'h00, 'h81,  0, 1, 'h81,  0, 1, memw('h80));
        tbl[20] = mk(0, 1, 1, 'h91, 'h82,  1, 0, 'h91,  1, 0, memw('h90));
        tbl[21] = mk(0, 0, 0, 'h00, 'h00,  0, 0, 'h00,  0, 1, memw('h81));
        tbl[22] = mk(0, 0, 0, 'h00, 'h00,  0, 0, 'h00,  1, 0, memw('h91));
        tbl[23] = mk(0, 0, 0, 'h00, 'h00,  0, 0, 'h00,  0, 0, 0);

        for (int i = 0; i < NV; i++) begin
            drive(tbl[i].rst, tbl[i].r0, tbl[i].r1, tbl[i].a0, tbl[i].a1);
            settle();
            check("l2_gnt0",   i, 32'(g0_2),  32'(tbl[i].g0));
            check("l2_gnt1",   i, 32'(g1_2),  32'(tbl[i].g1));
            check("l2_mem_en", i, 32'(en_2),  32'(tbl[i].en));
            check("l2_maddr",  i, ma_2,       tbl[i].ma);
            check("l2_rv0",    i, 32'(rv0_2), 32'(tbl[i].rv0));
            check("l2_rv1",    i, 32'(rv1_2), 32'(tbl[i].rv1));
            if (tbl[i].rv0) check("l2_rdata0", i, rd0_2, tbl[i].rd);
            if (tbl[i].rv1) check("l2_rdata1", i, rd1_2, tbl[i].rd);
            adv();
        end

        // LAT=1: req0 back-to-back on words 0..3
        drive(1, 0, 0, 0, 0);
        settle();
        check("l1_rst_en", 0, 32'(en_1), 0);
        adv();
        for (int t = 0; t < 6; t++) begin
            drive(0, t < 4, 0, 32'(t), 0);
            settle();
            check("l1_gnt0", t, 32'(g0_1),  32'(t < 4));
            check("l1_rv0",  t, 32'(rv0_1), 32'(t >= 1 && t <= 4));
            check("l1_rv1",  t, 32'(rv1_1), 0);
            if (t >= 1 && t <= 4) check("l1_rdata0", t, rd0_1, memw(32'(t - 1)));
            adv();
        end

        // LAT=3: two grants, then reset while both in flight
        drive(1, 0, 0, 0, 0);
        settle();
        adv();
        drive(0, 0, 1, 0, 'hB0);
        settle();
        check("l3_gnt1_a", 0, 32'(g1_3), 1);
        adv();
        drive(0, 1, 0, 'hA0, 0);
        settle();
        check("l3_gnt0_b", 1, 32'(g0_3), 1);
        adv();
        drive(1, 1, 1, 'hA1, 'hB1);
        settle();
        check("l3_rst_g0", 2, 32'(g0_3), 0);
        check("l3_rst_g1", 2, 32'(g1_3), 0);
        check("l3_rst_en", 2, 32'(en_3), 0);
        adv();
        for (int t = 3; t < 5; t++) begin
            drive(0, 0, 0, 0, 0);
            settle();
            check("l3_flush_rv0", t, 32'(rv0_3), 0);
            check("l3_flush_rv1", t, 32'(rv1_3), 0);
            adv();
        end
        drive(0, 1, 1, 'hC0, 'hC1);
        settle();
        check("l3_prio_g0", 5, 32'(g0_3), 1);
        check("l3_prio_g1", 5, 32'(g1_3), 0);
        check("l3_maddr",   5, ma_3, 'hC0);
        adv();
        for (int t = 6; t < 9; t++) begin
            drive(0, 0, 0, 0, 0);
            settle();
            check("l3_rv0", t, 32'(rv0_3), 32'(t == 8));
            check("l3_rv1", t, 32'(rv1_3), 0);
            if (t == 8) check("l3_rdata0", t, rd0_3, memw('hC0));
            adv();
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
